fft_out_serializer: RTL and testbench
=====================================

// Module: fft_out_serializer
// PURPOSE
//  Output end of the 16-point radix-2 DIF FFT datapath. Captures one 16-word parallel frame from the last
//  butterfly stage (each word packed {real[31:16], imag[15:0]}) and streams it out one bin per cycle in
//  natural order, k = 0..15, under a valid/ready handshake.
//  DIF stages deliver their results in bit-reversed order. This block undoes that order.
//  Ping-pong storage lets the FFT deliver frame n+1 while frame n is still draining.
// PARAMETERS
//  DW      16  width of each real/imag component (signed Q-format, passed through unchanged)
//  NPT     16  points per frame (only 16 is supported; index width = 4)
//  BITREV  1   1: reorder bit-reversed input to natural order; 0: emit words in input position order
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        frame_in holds a complete FFT frame
//  in_ready     out  1        a storage bank is free; frame is accepted when in_valid & in_ready
//  frame_in     in   16*2*DW  word p at [32p+31:32p], {re,im}; position p holds bin bitrev4(p)
//  out_valid    out  1        out_re/out_im/out_idx are valid
//  out_ready    in   1        sink accepts the current bin
//  out_re       out  DW       real part of bin out_idx
//  out_im       out  DW       imag part of bin out_idx
//  out_idx      out  4        bin number k being presented
//  frame_done   out  1        one-cycle pulse, the cycle after the 16th bin of a frame is accepted
// BEHAVIOUR
//  - Reset (async, any time): both banks EMPTY, wr_sel=0, rd_sel=0, cnt=0. out_valid=0, frame_done=0,
//    out_re/out_im/out_idx=0, in_ready=1. Any partially drained frame is discarded.
//  - Bank state per bank: EMPTY -> FULL on accept; FULL -> EMPTY on the last-bin handshake.
//  - in_ready = (bank[wr_sel] == EMPTY). It is driven from registers only, with no combinational path
//    from in_valid or out_ready.
//  - Accept (in_valid & in_ready at an edge): all 16 words are latched into bank[wr_sel]. That bank
//    becomes FULL and wr_sel toggles.
//  - Read FSM has two states:
//    - IDLE: out_valid=0. Move to SEND when bank[rd_sel] is FULL.
//    - SEND: out_valid=1, out_idx=cnt. out_{re,im} = bank[rd_sel][BITREV ? bitrev4(cnt) : cnt].
//  - Latency: the first bin is presented on the cycle after the accept edge (1 cycle).
//  - Handshake: while out_valid & !out_ready, out_* are held stable. On out_valid & out_ready, cnt++.
//  - Last bin (cnt==15 & out_ready): the bank goes EMPTY, rd_sel toggles, cnt wraps to 0, and
//    frame_done=1 on the next cycle. If the other bank is FULL, stay in SEND and present bin 0 of the next
//    frame immediately, with no bubble. Otherwise go to IDLE.
//  - Sustained throughput is 1 bin/cycle with out_ready held high. The FFT may present a frame every
//    16 cycles without stalling.
//  - Simultaneous accept and last-bin free in one cycle is legal. The write targets the other, empty bank.
//    The bank just freed raises in_ready on the following cycle.
//  - Both banks FULL: in_ready=0. in_valid is ignored, and frame_in need not be held stable.
//  - Arithmetic: none. Components pass bit-exact; the scaling (>>16) is done upstream in the stages.
// STRUCTURE
//  - Shared package fft_pkg, used by every fft_stage* and this block:
//    - FFT_DW=16, FFT_NPT=16, FFT_LOG2N=4.
//    - Complex word packing/unpacking macros or functions ({re,im}, 32 bits).
//    - function bitrev4(k).
//    - The W0..W7 twiddle constants.
//  - One sub-module, fft_frame_bank: a single 16x32 register bank with write-all and a 4-bit read
//    address, instantiated twice. The FSM, pointers and output mux stay in the top level.
// TESTING
//  1 Reset: assert rst mid-SEND at cnt=7 -> out_valid, frame_done and out_* go to 0 immediately.
//    in_ready=1. The next frame starts from out_idx=0.
//  2 Reorder: frame word p = {p, ~p}, out_ready=1 -> out_idx 0..15 gives out_re = 0,8,4,12,2,10,6,14,
//    1,9,5,13,3,11,7,15. frame_done pulses once, 17 cycles after the accept edge.
//  3 Backpressure: drop out_ready for 3 cycles at cnt=5 -> out_idx stays 5 and data is stable.
//    Exactly 16 handshakes occur per frame.
//  4 Back-to-back: 3 frames offered every 16 cycles with out_ready=1 -> 48 consecutive out_valid cycles
//    with no gap. in_valid is never stalled, and there are 3 frame_done pulses.
//  5 Full: out_ready=0, offer 3 frames -> the first two are accepted and in_ready=0 on the third.
//    After 16 handshakes, in_ready=1 and the third frame is then accepted.
//  6 BITREV=0: the same stimulus as test 2 -> out_re = 0..15 in order.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-2 DIF FFT datapath: sizes, complex word
// packing, index bit reversal and the twiddle table used by the butterfly stages.
package fft_pkg;

    localparam int unsigned FFT_DW    = 16;
    localparam int unsigned FFT_NPT   = 16;
    localparam int unsigned FFT_LOG2N = 4;
    localparam int unsigned FFT_CW    = 2 * FFT_DW;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    function automatic logic [FFT_CW-1:0] cplx_pack(input logic [FFT_DW-1:0] re,
                                                    input logic [FFT_DW-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [FFT_DW-1:0] cplx_re(input logic [FFT_CW-1:0] w);
        return w[FFT_CW-1:FFT_DW];
    endfunction

    function automatic logic [FFT_DW-1:0] cplx_im(input logic [FFT_CW-1:0] w);
        return w[FFT_DW-1:0];
    endfunction

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.15
    localparam cplx_t W0 = '{re:  16'sd32767, im:  16'sd0};
    localparam cplx_t W1 = '{re:  16'sd30274, im: -16'sd12540};
    localparam cplx_t W2 = '{re:  16'sd23170, im: -16'sd23170};
    localparam cplx_t W3 = '{re:  16'sd12540, im: -16'sd30274};
    localparam cplx_t W4 = '{re:  16'sd0,     im: -16'sd32767};
    localparam cplx_t W5 = '{re: -16'sd12540, im: -16'sd30274};
    localparam cplx_t W6 = '{re: -16'sd23170, im: -16'sd23170};
    localparam cplx_t W7 = '{re: -16'sd30274, im: -16'sd12540};

endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-in / bin-out handshake bundle of the FFT output serializer.
interface fft_out_serializer_if #(
    parameter int unsigned DW  = fft_pkg::FFT_DW,
    parameter int unsigned NPT = fft_pkg::FFT_NPT
);
    localparam int unsigned CW = 2 * DW;
    localparam int unsigned AW = fft_pkg::FFT_LOG2N;

    logic              in_valid;
    logic              in_ready;
    logic [NPT*CW-1:0] frame_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_re;
    logic [DW-1:0]     out_im;
    logic [AW-1:0]     out_idx;
    logic              frame_done;

    modport master (
        output in_valid, frame_in, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, frame_done
    );

    modport slave (
        input  in_valid, frame_in, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, frame_done
    );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame of storage: all words written in a single cycle, one word read by address.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned CW  = FFT_CW,
    parameter int unsigned NPT = FFT_NPT,
    parameter int unsigned AW  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NPT*CW-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CW-1:0]     rdata
);

    logic [CW-1:0] mem [NPT];

    // Contents are only read once the bank is marked full, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int p = 0; p < int'(NPT); p++) begin
                mem[p] <= wdata[p*CW +: CW];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer that streams a 16-point FFT frame one bin per cycle,
// undoing the bit-reversed order produced by the DIF stages.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int unsigned DW     = FFT_DW,
    parameter int unsigned NPT    = FFT_NPT,
    parameter bit          BITREV = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_out_serializer_if.slave  bus
);

    localparam int unsigned CW = 2 * DW;
    localparam int unsigned AW = FFT_LOG2N;

    typedef enum logic {
        RD_IDLE,
        RD_SEND
    } rd_state_t;

    rd_state_t     state, state_d;
    logic [1:0]    bank_full, full_d;
    logic          wr_sel, wr_sel_d;
    logic          rd_sel, rd_sel_d;
    logic [AW-1:0] cnt, cnt_d;

    logic          in_ready_q;
    logic          frame_done_q;
    logic [DW-1:0] out_re_q;
    logic [DW-1:0] out_im_q;
    logic [AW-1:0] out_idx_q;

    logic          accept;
    logic          hs;
    logic          last_hs;
    logic [1:0]    bank_we;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] bank_rdata [2];
    logic [CW-1:0] word_d;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .CW  (CW),
            .NPT (NPT),
            .AW  (AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .wdata (bus.frame_in),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    // Next-state view: outputs are registered from what the pointers will be after this edge.
    always_comb begin
        accept  = bus.in_valid & in_ready_q;
        hs      = (state == RD_SEND) & bus.out_ready;
        last_hs = hs & (cnt == AW'(NPT - 1));

        bank_we = 2'b00;
        full_d  = bank_full;
        if (accept) begin
            bank_we[wr_sel] = 1'b1;
            full_d[wr_sel]  = 1'b1;
        end
        if (last_hs) begin
            full_d[rd_sel] = 1'b0;
        end

        wr_sel_d = wr_sel ^ accept;
        rd_sel_d = rd_sel ^ last_hs;
        cnt_d    = hs ? cnt + AW'(1) : cnt;
        state_d  = full_d[rd_sel_d] ? RD_SEND : RD_IDLE;

        rd_addr = BITREV ? bitrev4(cnt_d) : cnt_d;

        // A bank written on this edge is not readable yet; take its word straight from the bus.
        if (accept && (wr_sel == rd_sel_d)) begin
            word_d = bus.frame_in[32'(rd_addr) * CW +: CW];
        end else begin
            word_d = bank_rdata[rd_sel_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RD_IDLE;
            bank_full    <= 2'b00;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            cnt          <= '0;
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_idx_q    <= '0;
        end else begin
            state        <= state_d;
            bank_full    <= full_d;
            wr_sel       <= wr_sel_d;
            rd_sel       <= rd_sel_d;
            cnt          <= cnt_d;
            in_ready_q   <= ~full_d[wr_sel_d];
            frame_done_q <= last_hs;
            if (state_d == RD_SEND) begin
                out_re_q  <= word_d[CW-1:DW];
                out_im_q  <= word_d[DW-1:0];
                out_idx_q <= cnt_d;
            end else begin
                out_re_q  <= '0;
                out_im_q  <= '0;
                out_idx_q <= '0;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state == RD_SEND);
    assign bus.out_re     = out_re_q;
    assign bus.out_im     = out_im_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: reorder, reset, backpressure, back-to-back,
// full-buffer and natural-order cases.
module tb_fft_out_serializer;

    localparam int unsigned NPT = 16;
    localparam int unsigned CW  = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_out_serializer_if bus_br  ();
    fft_out_serializer_if bus_nat ();

    fft_out_serializer #(.BITREV(1'b1)) u_dut_br (
        .clk (clk),
        .rst (rst),
        .bus (bus_br.slave)
    );

    fft_out_serializer #(.BITREV(1'b0)) u_dut_nat (
        .clk (clk),
        .rst (rst),
        .bus (bus_nat.slave)
    );

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    // Bin k of a frame sits at input position br_tab[k].
    int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) begin
        if (bus_br.out_valid && bus_br.out_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NPT*CW-1:0] mk_frame(input int f);
        logic [NPT*CW-1:0] fr;
        logic [15:0]       re;
        fr = '0;
        for (int p = 0; p < 16; p++) begin
            re = 16'(f * 256 + p);
            fr[p*32 +: 32] = {re, ~re};
        end
        return fr;
    endfunction

    // Accept frame f on the bit-reversing instance (one cycle of in_valid).
    task automatic offer_br(input int f);
        bus_br.frame_in = mk_frame(f);
        bus_br.in_valid = 1'b1;
        tick();
        bus_br.in_valid = 1'b0;
    endtask

    // Current sample shows bin 0 of frame f; drain all 16 bins, optionally stalling 3 cycles at bin stall_at.
    task automatic drain(input int f, input int stall_at);
        logic [15:0] er, ei, held;
        for (int k = 0; k < 16; k++) begin
            er = 16'(f * 256 + br_tab[k]);
            ei = ~er;
            if (k == stall_at) begin
                held = bus_br.out_re;
                bus_br.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_idx", 32'(bus_br.out_idx), 32'(k));
                    check("stall_re", 32'(bus_br.out_re), 32'(held));
                end
                bus_br.out_ready = 1'b1;
            end
            check("valid", 32'(bus_br.out_valid), 32'd1);
            check("idx", 32'(bus_br.out_idx), 32'(k));
            check("re", 32'(bus_br.out_re), 32'(er));
            check("im", 32'(bus_br.out_im), 32'(ei));
            tick();
        end
    endtask

    initial begin
        int vcnt;
        int dcnt;
        int hs0;
        int f;
        logic [15:0] er;
        logic [15:0] ei;

        bus_br.in_valid   = 1'b0;
        bus_br.out_ready  = 1'b0;
        bus_br.frame_in   = '0;
        bus_nat.in_valid  = 1'b0;
        bus_nat.out_ready = 1'b0;
        bus_nat.frame_in  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus_br.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_br.out_valid), 32'd0);
        check("rst_frame_done", 32'(bus_br.frame_done), 32'd0);
        check("rst_out_idx", 32'(bus_br.out_idx), 32'd0);
        rst = 1'b0;
        tick();

        // Reorder: bit-reversed positions come out in natural bin order
        bus_br.out_ready = 1'b1;
        offer_br(0);
        drain(0, -1);
        check("t2_done", 32'(bus_br.frame_done), 32'd1);
        check("t2_idle", 32'(bus_br.out_valid), 32'd0);
        tick();
        check("t2_done_clr", 32'(bus_br.frame_done), 32'd0);

        // Reset in the middle of a frame
        offer_br(1);
        repeat (7) tick();
        check("t1_idx7", 32'(bus_br.out_idx), 32'd7);
        rst = 1'b1;
        #1;
        check("t1_valid", 32'(bus_br.out_valid), 32'd0);
        check("t1_re", 32'(bus_br.out_re), 32'd0);
        check("t1_im", 32'(bus_br.out_im), 32'd0);
        check("t1_idx", 32'(bus_br.out_idx), 32'd0);
        check("t1_done", 32'(bus_br.frame_done), 32'd0);
        check("t1_in_ready", 32'(bus_br.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        offer_br(2);
        drain(2, -1);
        check("t1_done_after", 32'(bus_br.frame_done), 32'd1);
        tick();

        // Backpressure at bin 5
        hs0 = hs_cnt;
        offer_br(3);
        drain(3, 5);
        check("t3_done", 32'(bus_br.frame_done), 32'd1);
        check("t3_handshakes", 32'(hs_cnt - hs0), 32'd16);
        tick();

        // Three frames every 16 cycles: continuous output, no input stall
        vcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 52; c++) begin
            if ((c % 16 == 0) && (c < 48)) begin
                check("t4_in_ready", 32'(bus_br.in_ready), 32'd1);
                bus_br.frame_in = mk_frame(4 + c / 16);
                bus_br.in_valid = 1'b1;
            end else begin
                bus_br.in_valid = 1'b0;
            end
            tick();
            if (bus_br.out_valid) vcnt++;
            if (bus_br.frame_done) dcnt++;
            if (c < 48) begin
                f  = 4 + c / 16;
                er = 16'(f * 256 + br_tab[c % 16]);
                check("t4_valid", 32'(bus_br.out_valid), 32'd1);
                check("t4_idx", 32'(bus_br.out_idx), 32'(c % 16));
                check("t4_re", 32'(bus_br.out_re), 32'(er));
            end else begin
                check("t4_valid_end", 32'(bus_br.out_valid), 32'd0);
            end
        end
        check("t4_valid_cycles", 32'(vcnt), 32'd48);
        check("t4_done_pulses", 32'(dcnt), 32'd3);

        // Both banks full: third frame refused until a bank drains
        bus_br.out_ready = 1'b0;
        check("t5_rdy0", 32'(bus_br.in_ready), 32'd1);
        offer_br(8);
        check("t5_rdy1", 32'(bus_br.in_ready), 32'd1);
        offer_br(9);
        check("t5_rdy2", 32'(bus_br.in_ready), 32'd0);
        offer_br(10);
        check("t5_still_full", 32'(bus_br.in_ready), 32'd0);
        check("t5_held_idx", 32'(bus_br.out_idx), 32'd0);
        bus_br.out_ready = 1'b1;
        drain(8, -1);
        check("t5_rdy_free", 32'(bus_br.in_ready), 32'd1);
        bus_br.out_ready = 1'b0;
        offer_br(10);
        check("t5_rdy_after", 32'(bus_br.in_ready), 32'd0);
        bus_br.out_ready = 1'b1;
        drain(9, -1);
        drain(10, -1);
        check("t5_done", 32'(bus_br.frame_done), 32'd1);
        tick();

        // Natural-order instance passes positions straight through
        bus_nat.out_ready = 1'b1;
        bus_nat.frame_in  = mk_frame(0);
        bus_nat.in_valid  = 1'b1;
        tick();
        bus_nat.in_valid  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            er = 16'(k);
            ei = ~er;
            check("t6_valid", 32'(bus_nat.out_valid), 32'd1);
            check("t6_idx", 32'(bus_nat.out_idx), 32'(k));
            check("t6_re", 32'(bus_nat.out_re), 32'(er));
            check("t6_im", 32'(bus_nat.out_im), 32'(ei));
            tick();
        end
        check("t6_done", 32'(bus_nat.frame_done), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
